// File: rtl/onn_phase_sequencer.sv
// Run controller for the ONN neuron array: clears and loads the phase registers, steps the
// global phase counter and stops the run once the network settles or the period budget runs out.
module onn_phase_sequencer #(
  parameter int N_NEURONS      = 10,
  parameter int PHASE_W        = 4,
  parameter int STABLE_PERIODS = 3,
  parameter int MAX_PERIODS    = 255,
  parameter int CNT_W          = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           abort,
  input  logic                           cfg_valid,
  output logic                           cfg_ready,
  input  logic [PHASE_W-1:0]             cfg_phase,
  input  logic [N_NEURONS-1:0]           state_changed,
  output logic                           re,
  output logic                           full_tick,
  output logic [N_NEURONS*PHASE_W-1:0]   ini_phase_bus,
  output logic [PHASE_W-1:0]             phase_step,
  output logic                           busy,
  output logic                           done,
  output logic                           converged,
  output logic [CNT_W-1:0]               period_count
);

  localparam int IDX_W = $clog2(N_NEURONS + 1);
  localparam int STB_W = $clog2(STABLE_PERIODS + 1);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(N_NEURONS - 1);
  localparam logic [PHASE_W-1:0] STEP_MAX = '1;
  localparam logic [STB_W-1:0]   STB_DONE = STB_W'(STABLE_PERIODS);
  localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(MAX_PERIODS);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_LOAD, S_RUN, S_DONE} state_e;

  state_e            state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [STB_W-1:0]  stable_q;
  logic              chg_q;

  logic              chg_d;
  logic [STB_W-1:0]  stable_d;
  logic [CNT_W-1:0]  period_d;
  logic              boundary;

  // The boundary cycle's own state_changed sample is folded in before deciding stability.
  always_comb begin
    chg_d    = chg_q | (|state_changed);
    boundary = (phase_step == STEP_MAX);
    period_d = period_count + 1'b1;
    stable_d = chg_d ? '0 : stable_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      stable_q      <= '0;
      chg_q         <= 1'b0;
      cfg_ready     <= 1'b0;
      re            <= 1'b0;
      full_tick     <= 1'b0;
      ini_phase_bus <= '0;
      phase_step    <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      converged     <= 1'b0;
      period_count  <= '0;
    end else if (abort && (state_q != S_IDLE)) begin
      state_q    <= S_IDLE;
      chg_q      <= 1'b0;
      cfg_ready  <= 1'b0;
      re         <= 1'b0;
      full_tick  <= 1'b0;
      phase_step <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      converged  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            converged    <= 1'b0;
            period_count <= '0;
            re           <= 1'b1;
            busy         <= 1'b1;
            state_q      <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          re            <= 1'b0;
          idx_q         <= '0;
          ini_phase_bus <= '0;
          cfg_ready     <= 1'b1;
          state_q       <= S_LOAD;
        end
        S_LOAD: begin
          if (cfg_valid) begin
            for (int i = 0; i < N_NEURONS; i++) begin
              if (idx_q == IDX_W'(i)) ini_phase_bus[i*PHASE_W +: PHASE_W] <= cfg_phase;
            end
            idx_q <= idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
              cfg_ready  <= 1'b0;
              full_tick  <= 1'b1;
              phase_step <= '0;
              chg_q      <= 1'b0;
              stable_q   <= '0;
              state_q    <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (boundary) begin
            period_count <= period_d;
            stable_q     <= stable_d;
            chg_q        <= 1'b0;
            phase_step   <= '0;
            if (stable_d == STB_DONE) begin
              converged <= 1'b1;
              done      <= 1'b1;
              full_tick <= 1'b0;
              state_q   <= S_DONE;
            end else if (period_d == CNT_MAX) begin
              converged <= 1'b0;
              done      <= 1'b1;
              full_tick <= 1'b0;
              state_q   <= S_DONE;
            end
          end else begin
            chg_q      <= chg_d;
            phase_step <= phase_step + 1'b1;
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_onn_phase_sequencer.sv
// Directed bench for onn_phase_sequencer: load, convergence, timeout, boundary changes,
// cfg handshake gaps, abort and mid-run reset.
module tb_onn_phase_sequencer;

  localparam int N  = 10;
  localparam int PW = 4;
  localparam int CW = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic            cfg_valid = 1'b0;
  logic            cfg_ready;
  logic [PW-1:0]   cfg_phase = '0;
  logic [N-1:0]    state_changed = '0;
  logic            re;
  logic            full_tick;
  logic [N*PW-1:0] ini_phase_bus;
  logic [PW-1:0]   phase_step;
  logic            busy;
  logic            done;
  logic            converged;
  logic [CW-1:0]   period_count;

  int n_tests = 0;
  int n_fail  = 0;

  onn_phase_sequencer #(
    .N_NEURONS(N), .PHASE_W(PW), .STABLE_PERIODS(3), .MAX_PERIODS(255), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_phase(cfg_phase),
    .state_changed(state_changed), .re(re), .full_tick(full_tick),
    .ini_phase_bus(ini_phase_bus), .phase_step(phase_step), .busy(busy),
    .done(done), .converged(converged), .period_count(period_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_ready"}, 64'(cfg_ready), 64'd0);
    check({tag, "_re"}, 64'(re), 64'd0);
    check({tag, "_ftick"}, 64'(full_tick), 64'd0);
    check({tag, "_bus"}, 64'(ini_phase_bus), 64'd0);
    check({tag, "_step"}, 64'(phase_step), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_conv"}, 64'(converged), 64'd0);
    check({tag, "_pcnt"}, 64'(period_count), 64'd0);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load(input logic [N*PW-1:0] ph);
    for (int i = 0; i < N; i++) begin
      cfg_valid = 1'b1;
      cfg_phase = ph[i*PW +: PW];
      tick();
    end
    cfg_valid = 1'b0;
  endtask

  task automatic start_and_load(input logic [N*PW-1:0] ph);
    do_start();
    tick();
    load(ph);
  endtask

  // mode 0: quiet, 1: change on run cycle 15, 2: change on run cycle 20, 3: bit5 once per period
  task automatic run_until_done(input int mode, input int bound, output int cycles);
    int cnt;
    cnt = 0;
    while (!done && cnt < bound) begin
      case (mode)
        1:       state_changed = (cnt == 15) ? 10'h001 : 10'h000;
        2:       state_changed = (cnt == 20) ? 10'h200 : 10'h000;
        3:       state_changed = ((cnt % 16) == 7) ? 10'h020 : 10'h000;
        default: state_changed = '0;
      endcase
      tick();
      cnt++;
    end
    state_changed = '0;
    cycles = cnt;
    check("run_done_seen", 64'(done), 64'd1);
  endtask

  initial begin
    int cycles;
    int ready_hits;
    int done_hits;

    // power-on reset
    tick();
    tick();
    check_all_zero("por");
    rst_n = 1'b1;
    tick();

    // test 1: reset in the middle of LOAD
    do_start();
    tick();
    for (int i = 0; i < 4; i++) begin
      cfg_valid = 1'b1;
      cfg_phase = 4'hA;
      tick();
    end
    cfg_valid = 1'b0;
    check("t1_busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("t1_rst");
    tick();
    rst_n = 1'b1;
    tick();
    check("t1_idle_busy", 64'(busy), 64'd0);

    // test 2: quiet network converges after 3 periods
    do_start();
    check("t2_re_pulse", 64'(re), 64'd1);
    check("t2_busy", 64'(busy), 64'd1);
    check("t2_ready_clear", 64'(cfg_ready), 64'd0);
    tick();
    check("t2_re_drop", 64'(re), 64'd0);
    check("t2_ready_load", 64'(cfg_ready), 64'd1);
    check("t2_bus_cleared", 64'(ini_phase_bus), 64'd0);
    load(40'h9876543210);
    check("t2_ready_run", 64'(cfg_ready), 64'd0);
    check("t2_ftick", 64'(full_tick), 64'd1);
    check("t2_step0", 64'(phase_step), 64'd0);
    check("t2_bus", 64'(ini_phase_bus), 64'h9876543210);
    run_until_done(0, 500, cycles);
    check("t2_cycles", 64'(cycles), 64'd48);
    check("t2_conv", 64'(converged), 64'd1);
    check("t2_pcnt", 64'(period_count), 64'd3);
    check("t2_ftick_done", 64'(full_tick), 64'd0);
    check("t2_step_done", 64'(phase_step), 64'd0);
    tick();
    check("t2_done_pulse", 64'(done), 64'd0);
    check("t2_busy_idle", 64'(busy), 64'd0);
    check("t2_conv_held", 64'(converged), 64'd1);
    check("t2_bus_held", 64'(ini_phase_bus), 64'h9876543210);

    // test 5a: last change on a boundary cycle counts for that period
    start_and_load(40'h0123456789);
    run_until_done(1, 500, cycles);
    check("t5a_cycles", 64'(cycles), 64'd64);
    check("t5a_pcnt", 64'(period_count), 64'd4);
    check("t5a_conv", 64'(converged), 64'd1);
    tick();

    // test 5b: a mid-period change is remembered until the boundary
    start_and_load(40'h0123456789);
    run_until_done(2, 500, cycles);
    check("t5b_cycles", 64'(cycles), 64'd80);
    check("t5b_pcnt", 64'(period_count), 64'd5);
    tick();

    // test 4: cfg_valid outside LOAD is ignored; gapped cfg_valid gives exactly 10 accepts
    cfg_valid = 1'b1;
    cfg_phase = 4'hF;
    tick();
    tick();
    tick();
    cfg_valid = 1'b0;
    check("t4_idle_bus", 64'(ini_phase_bus), 64'h0123456789);
    do_start();
    tick();
    ready_hits = 0;
    for (int k = 0; k < 20; k++) begin
      if ((k % 2) == 0) begin
        cfg_valid = 1'b1;
        cfg_phase = 4'(15 - k / 2);
        if (cfg_ready) ready_hits++;
      end else begin
        cfg_valid = 1'b0;
        cfg_phase = 4'(k);
      end
      tick();
    end
    cfg_valid = 1'b0;
    check("t4_ready_hits", 64'(ready_hits), 64'd10);
    check("t4_bus", 64'(ini_phase_bus), 64'h6789ABCDEF);
    check("t4_ftick", 64'(full_tick), 64'd1);
    check("t4_step", 64'(phase_step), 64'd1);
    cfg_valid = 1'b1;
    cfg_phase = 4'h0;
    tick();
    tick();
    tick();
    cfg_valid = 1'b0;
    check("t4_run_bus", 64'(ini_phase_bus), 64'h6789ABCDEF);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_abort_busy", 64'(busy), 64'd0);

    // test 6: start during RUN ignored, abort returns to IDLE without done
    start_and_load(40'h1111111111);
    tick();
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t6_step", 64'(phase_step), 64'd4);
    check("t6_ftick", 64'(full_tick), 64'd1);
    check("t6_re", 64'(re), 64'd0);
    check("t6_busy", 64'(busy), 64'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t6_abort_busy", 64'(busy), 64'd0);
    check("t6_abort_ftick", 64'(full_tick), 64'd0);
    check("t6_abort_step", 64'(phase_step), 64'd0);
    check("t6_abort_conv", 64'(converged), 64'd0);
    check("t6_abort_re", 64'(re), 64'd0);
    done_hits = 0;
    for (int k = 0; k < 20; k++) begin
      if (done || busy) done_hits++;
      tick();
    end
    check("t6_no_done", 64'(done_hits), 64'd0);

    // test 3: one change per period never settles, so the run times out
    start_and_load(40'h0000000000);
    run_until_done(3, 5000, cycles);
    check("t3_cycles", 64'(cycles), 64'd4080);
    check("t3_pcnt", 64'(period_count), 64'd255);
    check("t3_conv", 64'(converged), 64'd0);
    done_hits = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (done) done_hits++;
    end
    check("t3_single_done", 64'(done_hits), 64'd0);
    check("t3_idle", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
